// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per uart_send request, LSB first, with a done/state handshake.
// Optional even parity bit between data and stop when UART_PARITY_EN is defined.
module uart_tx #(
  parameter int CLK_FREQ = 11059200,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_send,
  input  logic [7:0] send_data,
  output logic       txd,
  output logic       uart_send_done,
  output logic [3:0] uart_send_sta
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

  if (DIV < 2 || DIV >= 65536) begin : g_bad_div
    $error("uart_tx: CLK_FREQ/BAUD must be in [2, 65535]");
  end

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_DATA   = 4'd2,
    S_STOP   = 4'd3,
    S_PARITY = 4'd4,
    S_DONE   = 4'd9
  } state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  state_t      state, state_d;
  logic [15:0] bcnt, bcnt_d;
  logic [2:0]  bidx, bidx_d;
  logic [7:0]  sh, sh_d;
  logic        txd_d;
  logic        bit_end;
`ifdef UART_PARITY_EN
  logic        par, par_d;
`endif

  assign bit_end       = (bcnt == DIV_M1);
  assign uart_send_sta = state;

  always_comb begin
    state_d = state;
    bcnt_d  = bcnt;
    bidx_d  = bidx;
    sh_d    = sh;
`ifdef UART_PARITY_EN
    par_d   = par;
`endif
    case (state)
      S_IDLE: begin
        bcnt_d = '0;
        if (uart_send) begin
          sh_d    = send_data;
          bidx_d  = '0;
          state_d = S_START;
`ifdef UART_PARITY_EN
          par_d   = even_parity(send_data);
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          bcnt_d  = '0;
          state_d = S_DATA;
        end else begin
          bcnt_d = bcnt + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bcnt_d = '0;
          sh_d   = {1'b0, sh[7:1]};
          bidx_d = bidx + 3'd1;
          if (bidx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          bcnt_d = bcnt + 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          bcnt_d  = '0;
          state_d = S_STOP;
        end else begin
          bcnt_d = bcnt + 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          bcnt_d  = '0;
          state_d = S_DONE;
        end else begin
          bcnt_d = bcnt + 16'd1;
        end
      end
      S_DONE: begin
        bcnt_d = '0;
        if (!uart_send) state_d = S_IDLE;
      end
      // Unused codes (including PARITY when the feature is off) recover to IDLE.
      default: begin
        bcnt_d  = '0;
        state_d = S_IDLE;
      end
    endcase

    // txd is registered from the next state so the line changes on the same edge as the state.
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = sh_d[0];
`ifdef UART_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      bcnt           <= '0;
      bidx           <= '0;
      sh             <= '0;
      txd            <= 1'b1;
      uart_send_done <= 1'b0;
`ifdef UART_PARITY_EN
      par            <= 1'b0;
`endif
    end else begin
      state          <= state_d;
      bcnt           <= bcnt_d;
      bidx           <= bidx_d;
      sh             <= sh_d;
      txd            <= txd_d;
      uart_send_done <= (state_d == S_DONE);
`ifdef UART_PARITY_EN
      par            <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at DIV=16: expected per-bit line level and state code are queued
// when a request is driven, then popped and checked on every clock of that bit slot.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_send = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       txd;
  logic       uart_send_done;
  logic [3:0] uart_send_sta;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       b;
    logic [3:0] sta;
  } slot_t;

  slot_t exp_q[$];

  uart_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_send      (uart_send),
    .send_data      (send_data),
    .txd            (txd),
    .uart_send_done (uart_send_done),
    .uart_send_sta  (uart_send_sta)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    slot_t s;
    s.b = 1'b0; s.sta = 4'd1; exp_q.push_back(s);
    for (int i = 0; i < 8; i++) begin
      s.b = d[i]; s.sta = 4'd2; exp_q.push_back(s);
    end
`ifdef UART_PARITY_EN
    s.b = ^d; s.sta = 4'd4; exp_q.push_back(s);
`endif
    s.b = 1'b1; s.sta = 4'd3; exp_q.push_back(s);
  endtask

  // Request a byte and check every clock of the frame; optionally corrupt send_data after edge N+20.
  task automatic run_frame(input logic [7:0] d, input bit corrupt);
    slot_t s;
    int    n;
    @(negedge clk);
    send_data = d;
    uart_send = 1'b1;
    push_frame(d);
    n = 0;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      for (int j = 0; j < DIV; j++) begin
        @(negedge clk);
        check("txd", txd, s.b);
        check("sta", uart_send_sta, s.sta);
        check("done_low", uart_send_done, 0);
        n++;
        if (corrupt && n == 21) send_data = 8'h00;
      end
    end
    @(negedge clk);
    check("done_sta", uart_send_sta, 9);
    check("done_flag", uart_send_done, 1);
    check("done_txd", txd, 1);
  endtask

  // Hold the request through DONE for some clocks, then drop it and expect IDLE.
  task automatic end_frame(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_sta", uart_send_sta, 9);
      check("hold_txd", txd, 1);
      check("hold_done", uart_send_done, 1);
    end
    uart_send = 1'b0;
    @(negedge clk);
    check("release_sta", uart_send_sta, 0);
    check("release_done", uart_send_done, 0);
    check("release_txd", txd, 1);
  endtask

  initial begin
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_send = 1'($urandom_range(0, 1));
      send_data = 8'($urandom);
      check("rst_txd", txd, 1);
      check("rst_sta", uart_send_sta, 0);
      check("rst_done", uart_send_done, 0);
    end
    uart_send = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_sta", uart_send_sta, 0);

    run_frame(8'h55, 1'b0);
    end_frame(50);

    run_frame(8'hA5, 1'b1);
    end_frame(0);

    // Abort during data bit 3 with an asynchronous reset between clock edges.
    @(negedge clk);
    send_data = 8'h3C;
    uart_send = 1'b1;
    repeat (4 * DIV + 5) @(negedge clk);
    check("pre_abort_sta", uart_send_sta, 2);
    #2 rst = 1'b0;
    uart_send = 1'b0;
    #1;
    check("abort_txd", txd, 1);
    check("abort_sta", uart_send_sta, 0);
    check("abort_done", uart_send_done, 0);
    @(negedge clk);
    check("abort_hold_txd", txd, 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_resume_sta", uart_send_sta, 0);
    check("abort_no_resume_txd", txd, 1);

    run_frame(8'h0F, 1'b0);
    end_frame(0);

`ifdef UART_PARITY_EN
    run_frame(8'h07, 1'b0);
    end_frame(0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
